// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryptor, one round per clock; AES_ZEROIZE_EN clears ct_out/state/key residue
module aes_mix_columns (
   input  logic [127:0] d,
   output logic [127:0] q
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign {a0, a1, a2, a3} = d[127-32*c -: 32];
      assign q[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   end
endmodule

module aes_round_sequencer (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] pt_in,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ct_out,
   output logic         busy,
   output logic [3:0]   round,
   output logic [127:0] sb_in,
   input  logic [127:0] sb_out,
   output logic [31:0]  sw_in,
   input  logic [31:0]  sw_out
);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;
   fsm_e fsm_q, fsm_d;
   logic [127:0] st_q, st_d, rk_q, rk_d, mc, nk;
   logic [7:0] rcon_q, rcon_d;
   logic [3:0] round_q, round_d;
   logic [31:0] t, w0, w1, w2, w3;
   logic last;
   aes_mix_columns u_mc (.d(sb_out), .q(mc));
   assign last = round_q == 4'd10;
   assign t = {sw_out[23:0], sw_out[31:24]} ^ {rcon_q, 24'h0};
   assign w0 = rk_q[127:96] ^ t;
   assign w1 = rk_q[95:64] ^ w0;
   assign w2 = rk_q[63:32] ^ w1;
   assign w3 = rk_q[31:0] ^ w2;
   assign nk = {w0, w1, w2, w3};
   always_comb begin
      fsm_d = fsm_q;
      st_d = st_q;
      rk_d = rk_q;
      rcon_d = rcon_q;
      round_d = round_q;
      case (fsm_q)
         IDLE: if (in_valid) begin
            fsm_d = ROUND;
            st_d = pt_in ^ key_in;
            rk_d = key_in;
            rcon_d = 8'h01;
            round_d = 4'd1;
         end
         ROUND: begin
            fsm_d = last ? DONE : ROUND;
            st_d = (last ? sb_out : mc) ^ nk;
            rk_d = nk;
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            round_d = last ? round_q : round_q + 4'd1;
         end
         DONE: if (out_ready) begin
            fsm_d = IDLE;
            round_d = '0;
`ifdef AES_ZEROIZE_EN
            st_d = '0;
            rk_d = '0;
`endif
         end
         default: fsm_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q <= IDLE;
         st_q <= '0;
         rk_q <= '0;
         rcon_q <= '0;
         round_q <= '0;
      end else begin
         fsm_q <= fsm_d;
         st_q <= st_d;
         rk_q <= rk_d;
         rcon_q <= rcon_d;
         round_q <= round_d;
      end
   end
   assign in_ready = fsm_q == IDLE;
   assign out_valid = fsm_q == DONE;
   assign busy = fsm_q != IDLE;
   assign round = round_q;
   assign sb_in = st_q;
   assign sw_in = rk_q[31:0];
`ifdef AES_ZEROIZE_EN
   assign ct_out = out_valid ? st_q : '0;
`else
   assign ct_out = st_q;
`endif
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed and random checks of aes_round_sequencer against a byte-level AES model
module tb_aes_round_sequencer;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
   logic in_ready, out_valid, busy;
   logic [127:0] pt_in = '0, key_in = '0, ct_out, sb_in, sb_out;
   logic [3:0] round;
   logic [31:0] sw_in, sw_out;
   int n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   aes_round_sequencer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pt_in(pt_in), .key_in(key_in), .out_valid(out_valid), .out_ready(out_ready),
      .ct_out(ct_out), .busy(busy), .round(round), .sb_in(sb_in), .sb_out(sb_out),
      .sw_in(sw_in), .sw_out(sw_out)
   );
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r = 8'h01, p = x, e = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[0]) r = gmul(r, p);
         p = gmul(p, p);
         e = e >> 1;
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction
   function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [127:0] k);
      logic [7:0] s[16], w[16], t[16], tmp[4];
      logic [7:0] rc = 8'h01;
      logic [127:0] o;
      for (int i = 0; i < 16; i++) begin
         w[i] = k[127-8*i -: 8];
         s[i] = p[127-8*i -: 8] ^ w[i];
      end
      for (int r = 1; r <= 10; r++) begin
         tmp = '{sbox(w[13]) ^ rc, sbox(w[14]), sbox(w[15]), sbox(w[12])};
         for (int j = 0; j < 4; j++) w[j] = w[j] ^ tmp[j];
         for (int j = 4; j < 16; j++) w[j] = w[j] ^ w[j-4];
         rc = gmul(rc, 8'h02);
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) t[4*c+q] = sbox(s[4*((c+q)%4)+q]);
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
               s[4*c+q] = (r < 10 ? gmul(t[4*c+q], 8'h02) ^ gmul(t[4*c+(q+1)%4], 8'h03) ^
                           t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4] : t[4*c+q]) ^ w[4*c+q];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction
   always_comb begin
      sb_out = '0;
      for (int c = 0; c < 4; c++)
         for (int q = 0; q < 4; q++)
            sb_out[127-8*(4*c+q) -: 8] = sbox(sb_in[127-8*(4*((c+q)%4)+q) -: 8]);
      sw_out = {sbox(sw_in[31:24]), sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0])};
   end
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction
   task automatic run_op(input logic [127:0] p, input logic [127:0] k, input logic [127:0] exp,
                         input int hold, input string tag);
      pt_in = p;
      key_in = k;
      in_valid = 1;
      chk({tag, " in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 0;
      for (int r = 1; r <= 10; r++) begin
         chk($sformatf("%s round%0d", tag, r), round, r);
         chk({tag, " early out_valid"}, out_valid, 0);
         chk({tag, " busy"}, busy, 1);
`ifdef AES_ZEROIZE_EN
         chk({tag, " zeroized ct_out"}, ct_out, 0);
`endif
         @(negedge clk);
      end
      chk({tag, " out_valid"}, out_valid, 1);
      chk({tag, " final round"}, round, 10);
      chk({tag, " ct"}, ct_out, exp);
      repeat (hold) @(negedge clk);
      chk({tag, " held ct"}, ct_out, exp);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk({tag, " idle in_ready"}, in_ready, 1);
      chk({tag, " idle out_valid"}, out_valid, 0);
      chk({tag, " idle round"}, round, 0);
      chk({tag, " idle busy"}, busy, 0);
`ifdef AES_ZEROIZE_EN
      chk({tag, " idle ct_out"}, ct_out, 0);
      chk({tag, " idle sb_in"}, sb_in, 0);
      chk({tag, " idle sw_in"}, sw_in, 0);
`endif
   endtask
   initial begin
      logic [127:0] p1, k1, p2, k2, held;
      repeat (3) @(negedge clk);
      chk("rst out_valid", out_valid, 0);
      chk("rst busy", busy, 0);
      chk("rst round", round, 0);
      chk("rst in_ready", in_ready, 1);
      chk("rst ct_out", ct_out, 0);
      chk("rst sb_in", sb_in, 0);
      chk("rst sw_in", sw_in, 0);
      rst = 0;
      @(negedge clk);
      chk("post-rst in_ready", in_ready, 1);
      run_op(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
             128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, "fips_c1");
      run_op(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3925841d02dc09fbdc118597196a0b32, 1, "fips_b");
      p1 = rnd128();
      k1 = rnd128();
      pt_in = p1;
      key_in = k1;
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      repeat (10) @(negedge clk);
      chk("bp out_valid", out_valid, 1);
      held = aes_ref(p1, k1);
      for (int i = 0; i < 20; i++) begin
         chk("bp ct stable", ct_out, held);
         chk("bp in_ready", in_ready, 0);
         chk("bp out_valid held", out_valid, 1);
         in_valid = 1'($urandom_range(0, 1));
         pt_in = rnd128();
         key_in = rnd128();
         @(negedge clk);
      end
      in_valid = 0;
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("bp release in_ready", in_ready, 1);
      chk("bp release out_valid", out_valid, 0);
      @(negedge clk);
      chk("bp nothing queued", busy, 0);
      p1 = rnd128();
      k1 = rnd128();
      p2 = rnd128();
      k2 = rnd128();
      pt_in = p1;
      key_in = k1;
      in_valid = 1;
      out_ready = 1;
      @(negedge clk);
      pt_in = p2;
      key_in = k2;
      repeat (9) @(negedge clk);
      chk("b2b first not early", out_valid, 0);
      @(negedge clk);
      chk("b2b first valid", out_valid, 1);
      chk("b2b first ct", ct_out, aes_ref(p1, k1));
      @(negedge clk);
      chk("b2b gap in_ready", in_ready, 1);
      chk("b2b gap out_valid", out_valid, 0);
      @(negedge clk);
      in_valid = 0;
      chk("b2b second busy", busy, 1);
      chk("b2b second round", round, 1);
      repeat (10) @(negedge clk);
      chk("b2b second valid", out_valid, 1);
      chk("b2b second ct", ct_out, aes_ref(p2, k2));
      @(negedge clk);
      out_ready = 0;
      chk("b2b end in_ready", in_ready, 1);
      pt_in = rnd128();
      key_in = rnd128();
      in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      repeat (4) @(negedge clk);
      chk("mid round5", round, 5);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("mid rst busy", busy, 0);
      chk("mid rst round", round, 0);
      chk("mid rst in_ready", in_ready, 1);
      chk("mid rst out_valid", out_valid, 0);
      for (int i = 0; i < 12; i++) begin
         chk("mid rst no output", out_valid, 0);
         @(negedge clk);
      end
      p1 = rnd128();
      k1 = rnd128();
      run_op(p1, k1, aes_ref(p1, k1), 0, "after_rst");
      for (int n = 0; n < 12; n++) begin
         p1 = rnd128();
         k1 = rnd128();
         run_op(p1, k1, aes_ref(p1, k1), $urandom_range(0, 3), $sformatf("rand%0d", n));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
